// File: rtl/board_pkg.sv
// Shared types and constants for the board renderer.
//   cell_t       : 2-bit cell code (empty, player 1, player 2, win mark)
//   state_t      : write/clear controller state
//   cell_index() : row-major flat cell index (row * 7 + col)
package board_pkg;

    typedef enum logic [1:0] {
        CellEmpty = 2'd0,
        CellP1    = 2'd1,
        CellP2    = 2'd2,
        CellWin   = 2'd3
    } cell_t;

    typedef enum logic {
        StIdle  = 1'b0,
        StClear = 1'b1
    } state_t;

    localparam int BOARD_COLS   = 7;
    localparam int BOARD_ROWS   = 6;
    localparam int NUM_CELLS    = BOARD_COLS * BOARD_ROWS;
    localparam int CELL_PX      = 80;
    localparam int BOARD_X0     = 40;
    localparam int DISC_C       = 40;    // disc centre inside a cell, both axes
    localparam int DISC_R2      = 1024;  // radius 32, squared
    localparam int BORDER_PX    = 4;     // cursor frame thickness
    localparam int BLINK_FRAMES = 30;

    localparam logic [23:0] COLOUR_BLACK  = 24'h000000;
    localparam logic [23:0] COLOUR_BOARD  = 24'h0000C0;
    localparam logic [23:0] COLOUR_P1     = 24'hFF0000;
    localparam logic [23:0] COLOUR_P2     = 24'hFFFF00;
    localparam logic [23:0] COLOUR_WIN    = 24'h00FF00;
    localparam logic [23:0] COLOUR_CURSOR = 24'hFFFFFF;

    function automatic logic [5:0] cell_index(input logic [2:0] row, input logic [2:0] col);
        return 6'(int'(row) * BOARD_COLS + int'(col));
    endfunction

endpackage

// File: rtl/board_renderer_if.sv
// Cell-write / clear request bundle between a game controller and the renderer.
//   wr_valid/wr_ready : write handshake, transfer when both high at a clock edge
//   wr_col, wr_row    : target cell (col 0-6, row 0-5; anything else is dropped)
//   wr_data           : cell code to store
//   clear             : single-cycle request to empty the board
interface board_renderer_if;

    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_col;
    logic [2:0] wr_row;
    logic [1:0] wr_data;
    logic       clear;

    modport master (
        output wr_valid, wr_col, wr_row, wr_data, clear,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_col, wr_row, wr_data, clear,
        output wr_ready
    );

endinterface

// File: rtl/cell_locator.sv
// Combinational pixel-to-cell mapper.
//   pixel_x_i, pixel_y_i : visible pixel coordinates
//   on_board_o           : pixel lies within x 40..599, y 0..479
//   col_o, idx_o         : board column and row-major cell index of the pixel
//   in_disc_o            : pixel lies inside the cell's disc
//   on_border_o          : pixel lies in the 4-pixel frame of its cell
module cell_locator
    import board_pkg::*;
(
    input  logic [9:0] pixel_x_i,
    input  logic [9:0] pixel_y_i,
    output logic       on_board_o,
    output logic [2:0] col_o,
    output logic [5:0] idx_o,
    output logic       in_disc_o,
    output logic       on_border_o
);

    int px, py, col_n, row_n, lx, ly, dx, dy;

    // Column/row found by comparing against cell boundaries rather than dividing.
    always_comb begin
        px    = int'(pixel_x_i);
        py    = int'(pixel_y_i);
        col_n = 0;
        for (int c = 1; c < BOARD_COLS; c++) begin
            if (px >= BOARD_X0 + c * CELL_PX) col_n = c;
        end
        row_n = 0;
        for (int r = 1; r < BOARD_ROWS; r++) begin
            if (py >= r * CELL_PX) row_n = r;
        end
        lx = px - BOARD_X0 - col_n * CELL_PX;
        ly = py - row_n * CELL_PX;
        dx = lx - DISC_C;
        dy = ly - DISC_C;
    end

    assign on_board_o  = (px >= BOARD_X0) && (px < BOARD_X0 + BOARD_COLS * CELL_PX) &&
                         (py < BOARD_ROWS * CELL_PX);
    assign col_o       = 3'(col_n);
    assign idx_o       = cell_index(3'(row_n), 3'(col_n));
    assign in_disc_o   = (dx * dx + dy * dy) < DISC_R2;
    assign on_border_o = (lx < BORDER_PX) || (lx >= CELL_PX - BORDER_PX) ||
                         (ly < BORDER_PX) || (ly >= CELL_PX - BORDER_PX);

endmodule

// File: rtl/board_renderer.sv
// Seven-by-six board renderer for a 640x480 display.
//   clk, reset                : pixel clock, asynchronous active-high reset
//   video_on, pixel_x/pixel_y : visible flag and coordinates from the timing generator
//   hsync_in, vsync_in        : active-low syncs from the timing generator
//   cursor_col                : highlighted column (7 = no cursor)
//   wr                        : cell write / clear requests (slave side)
//   red, green, blue          : pixel colour, two cycles after its coordinates
//   hsync, vsync              : syncs delayed to line up with the colour
// Writes land in a pending board that is copied to the displayed board at each frame start,
// so a frame never shows a half-updated board.
module board_renderer
    import board_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             video_on,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic [2:0]       cursor_col,
    board_renderer_if.slave  wr,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             hsync,
    output logic             vsync
);

    // ---------------- board storage and write/clear control ----------------
    state_t      state_q, state_d;
    logic [5:0]  clr_idx_q, clr_idx_d;
    logic [83:0] pending_q, pending_d;
    logic [83:0] display_q, display_d;
    logic        vsync_prev_q;
    logic [4:0]  frame_q, frame_d;
    logic        blink_q, blink_d;
    logic        wr_ready, wr_fire, wr_in_range, frame_start;

    assign wr_ready    = (state_q == StIdle) && !wr.clear;
    assign wr.wr_ready = wr_ready;
    assign wr_fire     = wr.wr_valid && wr_ready;
    assign wr_in_range = (wr.wr_col < 3'(BOARD_COLS)) && (wr.wr_row < 3'(BOARD_ROWS));
    assign frame_start = vsync_prev_q && !vsync_in;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        pending_d = pending_q;
        display_d = display_q;
        frame_d   = frame_q;
        blink_d   = blink_q;

        unique case (state_q)
            StIdle: begin
                if (wr.clear) begin
                    state_d   = StClear;
                    clr_idx_d = '0;
                end else if (wr_fire && wr_in_range) begin
                    pending_d[{cell_index(wr.wr_row, wr.wr_col), 1'b0} +: 2] = wr.wr_data;
                end
            end
            StClear: begin
                pending_d[{clr_idx_q, 1'b0} +: 2] = CellEmpty;
                if (clr_idx_q == 6'(NUM_CELLS - 1)) begin
                    state_d   = StIdle;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 6'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (frame_start) begin
            // Copy the pre-edge pending board: a same-cycle write shows next frame.
            if (state_q != StClear) display_d = pending_q;
            if (frame_q == 5'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                blink_d = !blink_q;
            end else begin
                frame_d = frame_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            clr_idx_q    <= '0;
            pending_q    <= '0;
            display_q    <= '0;
            vsync_prev_q <= 1'b1;  // idle-high sync: no false frame start out of reset
            frame_q      <= '0;
            blink_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            pending_q    <= pending_d;
            display_q    <= display_d;
            vsync_prev_q <= vsync_in;
            frame_q      <= frame_d;
            blink_q      <= blink_d;
        end
    end

    // ---------------- stage 1: cell location ----------------
    logic       loc_on_board, loc_in_disc, loc_on_border;
    logic [2:0] loc_col;
    logic [5:0] loc_idx;

    cell_locator u_cell_locator (
        .pixel_x_i   (pixel_x),
        .pixel_y_i   (pixel_y),
        .on_board_o  (loc_on_board),
        .col_o       (loc_col),
        .idx_o       (loc_idx),
        .in_disc_o   (loc_in_disc),
        .on_border_o (loc_on_border)
    );

    logic       s1_video_q, s1_on_board_q, s1_disc_q, s1_border_q, s1_hsync_q, s1_vsync_q;
    logic [2:0] s1_col_q;
    logic [5:0] s1_idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_video_q    <= 1'b0;
            s1_on_board_q <= 1'b0;
            s1_disc_q     <= 1'b0;
            s1_border_q   <= 1'b0;
            s1_col_q      <= '0;
            s1_idx_q      <= '0;
            s1_hsync_q    <= 1'b1;
            s1_vsync_q    <= 1'b1;
        end else begin
            s1_video_q    <= video_on;
            s1_on_board_q <= loc_on_board;
            s1_disc_q     <= loc_in_disc;
            s1_border_q   <= loc_on_border;
            s1_col_q      <= loc_col;
            s1_idx_q      <= loc_idx;
            s1_hsync_q    <= hsync_in;
            s1_vsync_q    <= vsync_in;
        end
    end

    // ---------------- stage 2: colour ----------------
    cell_t       s1_cell;
    logic [23:0] colour_d, colour_q;
    logic        hsync_q, vsync_q;

    assign s1_cell = cell_t'(display_q[{s1_idx_q, 1'b0} +: 2]);

    always_comb begin
        colour_d = COLOUR_BLACK;
        if (s1_video_q && s1_on_board_q) begin
            if (blink_q && s1_border_q && (s1_col_q == cursor_col)) begin
                colour_d = COLOUR_CURSOR;
            end else if (s1_disc_q) begin
                unique case (s1_cell)
                    CellEmpty: colour_d = COLOUR_BLACK;
                    CellP1:    colour_d = COLOUR_P1;
                    CellP2:    colour_d = COLOUR_P2;
                    CellWin:   colour_d = COLOUR_WIN;
                endcase
            end else begin
                colour_d = COLOUR_BOARD;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            colour_q <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
        end else begin
            colour_q <= colour_d;
            hsync_q  <= s1_hsync_q;
            vsync_q  <= s1_vsync_q;
        end
    end

    assign red   = colour_q[23:16];
    assign green = colour_q[15:8];
    assign blue  = colour_q[7:0];
    assign hsync = hsync_q;
    assign vsync = vsync_q;

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer: fixed pixel table, hand sequences for latency,
// sync delay, clear, blink and reset corners, then random writes/frames/pixels checked
// against a board-level reference model.
module tb_board_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic       video_on;
    logic [9:0] pixel_x, pixel_y;
    logic       hsync_in, vsync_in;
    logic [2:0] cursor_col;
    logic [7:0] red, green, blue;
    logic       hsync, vsync;

    board_renderer_if wr_if ();

    board_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .cursor_col (cursor_col),
        .wr         (wr_if),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync      (hsync),
        .vsync      (vsync)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: boards as plain arrays of codes, row-major.
    int ref_pend[42];
    int ref_disp[42];
    int ref_frames;
    bit ref_blink;

    typedef struct {
        int          x;
        int          y;
        bit          vid;
        logic [23:0] exp;
    } vec_t;
    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 42; i++) begin
            ref_pend[i] = 0;
            ref_disp[i] = 0;
        end
        ref_frames = 0;
        ref_blink  = 1'b1;
    endtask

    // One frame start while the board is not being cleared.
    task automatic ref_frame();
        for (int i = 0; i < 42; i++) ref_disp[i] = ref_pend[i];
        if (ref_frames == 29) begin
            ref_frames = 0;
            ref_blink  = !ref_blink;
        end else begin
            ref_frames++;
        end
    endtask

    function automatic logic [23:0] ref_rgb(input int x, input int y, input bit vid,
                                            input int cur);
        int col, row, lx, ly;
        if (!vid) return 24'h000000;
        if (x < 40 || x >= 600 || y >= 480) return 24'h000000;
        col = (x - 40) / 80;
        row = y / 80;
        lx  = (x - 40) % 80;
        ly  = y % 80;
        if (ref_blink && cur == col && (lx < 4 || lx >= 76 || ly < 4 || ly >= 76))
            return 24'hFFFFFF;
        if ((lx - 40) * (lx - 40) + (ly - 40) * (ly - 40) < 1024) begin
            case (ref_disp[row * 7 + col])
                1:       return 24'hFF0000;
                2:       return 24'hFFFF00;
                3:       return 24'h00FF00;
                default: return 24'h000000;
            endcase
        end
        return 24'h0000C0;
    endfunction

    task automatic check_pixel(input string name, input int x, input int y, input bit vid,
                               input logic [23:0] exp);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = vid;
        tick();
        tick();
        check(name, {8'h00, red, green, blue}, {8'h00, exp});
    endtask

    task automatic frame_start();
        vsync_in = 1'b0;
        tick();
        ref_frame();
        vsync_in = 1'b1;
        tick();
    endtask

    task automatic do_write(input int col, input int row, input int data);
        int waited = 0;
        wr_if.wr_col   = 3'(col);
        wr_if.wr_row   = 3'(row);
        wr_if.wr_data  = 2'(data);
        wr_if.wr_valid = 1'b1;
        #1;
        while (!wr_if.wr_ready && waited < 100) begin
            tick();
            waited++;
        end
        n_checks++;
        if (!wr_if.wr_ready) begin
            n_errors++;
            $display("FAIL write_ack: got ready=0, want ready=1 within 100 cycles");
        end else begin
            tick();
            if (col < 7 && row < 6) ref_pend[row * 7 + col] = data;
        end
        wr_if.wr_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        int x, y, c, r, op;
        logic [23:0] e;

        vecs[0]  = '{320, 440, 1'b1, 24'hFF0000};  // centre of col3,row5
        vecs[1]  = '{280, 440, 1'b1, 24'h0000C0};  // left edge of that cell, outside disc
        vecs[2]  = '{45,    5, 1'b1, 24'h0000C0};
        vecs[3]  = '{20,  100, 1'b1, 24'h000000};
        vecs[4]  = '{320, 440, 1'b0, 24'h000000};
        vecs[5]  = '{600,  10, 1'b1, 24'h000000};
        vecs[6]  = '{599, 479, 1'b1, 24'h0000C0};
        vecs[7]  = '{80,   40, 1'b1, 24'h000000};  // empty disc
        vecs[8]  = '{351, 440, 1'b1, 24'hFF0000};  // dx=31 inside
        vecs[9]  = '{352, 440, 1'b1, 24'h0000C0};  // dx=32 on radius, outside
        vecs[10] = '{320, 409, 1'b1, 24'hFF0000};  // dy=-31 inside
        vecs[11] = '{320, 408, 1'b1, 24'h0000C0};  // dy=-32 outside
        vecs[12] = '{40,    0, 1'b1, 24'h0000C0};
        vecs[13] = '{639,   0, 1'b1, 24'h000000};

        reset          = 1'b1;
        video_on       = 1'b0;
        pixel_x        = '0;
        pixel_y        = '0;
        hsync_in       = 1'b1;
        vsync_in       = 1'b1;
        cursor_col     = 3'd7;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_col   = '0;
        wr_if.wr_row   = '0;
        wr_if.wr_data  = '0;
        wr_if.clear    = 1'b0;
        ref_reset();

        // Reset values.
        tick();
        tick();
        check("rst_rgb", {8'h00, red, green, blue}, 32'h0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        reset = 1'b0;
        tick();
        check("rst_ready", wr_if.wr_ready, 1);

        // Write is invisible until the next frame start.
        do_write(3, 5, 1);
        check_pixel("pre_frame", 320, 440, 1'b1, 24'h000000);
        frame_start();
        for (int i = 0; i < 14; i++)
            check_pixel($sformatf("table%0d", i), vecs[i].x, vecs[i].y, vecs[i].vid, vecs[i].exp);

        // Two-cycle colour latency.
        check_pixel("lat_pre", 20, 100, 1'b1, 24'h000000);
        pixel_x = 10'd320;
        pixel_y = 10'd440;
        tick();
        check("lat_1cyc", {8'h00, red, green, blue}, 32'h000000);
        tick();
        check("lat_2cyc", {8'h00, red, green, blue}, 32'hFF0000);

        // Sync delay.
        hsync_in = 1'b0;
        tick();
        check("hs_1cyc", hsync, 1);
        tick();
        check("hs_2cyc", hsync, 0);
        hsync_in = 1'b1;
        tick();
        check("hs_hold", hsync, 0);
        tick();
        check("hs_rise", hsync, 1);
        vsync_in = 1'b0;
        tick();
        ref_frame();
        check("vs_1cyc", vsync, 1);
        vsync_in = 1'b1;
        tick();
        check("vs_2cyc", vsync, 0);
        tick();
        check("vs_rise", vsync, 1);

        // Clear with a colliding write; clear requests during CLEAR are ignored.
        do_write(0, 0, 2);
        do_write(6, 5, 3);
        frame_start();
        check_pixel("pre_clr_p2", 80, 40, 1'b1, 24'hFFFF00);
        check_pixel("pre_clr_win", 560, 440, 1'b1, 24'h00FF00);
        wr_if.wr_col   = 3'd0;
        wr_if.wr_row   = 3'd5;
        wr_if.wr_data  = 2'd2;
        wr_if.wr_valid = 1'b1;
        wr_if.clear    = 1'b1;
        #1;
        check("clr_prio_ready", wr_if.wr_ready, 0);
        for (int i = 0; i < 42; i++) begin
            tick();
            if (i == 0) begin
                wr_if.wr_valid = 1'b0;
                wr_if.clear    = 1'b0;
            end
            if (i == 10) wr_if.clear = 1'b1;
            if (i == 11) wr_if.clear = 1'b0;
            #1;
            check($sformatf("clr_busy%0d", i), wr_if.wr_ready, 0);
        end
        tick();
        check("clr_done", wr_if.wr_ready, 1);
        for (int i = 0; i < 42; i++) ref_pend[i] = 0;
        frame_start();
        for (int i = 0; i < 42; i++)
            check_pixel($sformatf("clr_cell%0d", i), 80 + 80 * (i % 7), 40 + 80 * (i / 7),
                        1'b1, 24'h000000);

        // Cursor blink across 30-frame periods.
        cursor_col = 3'd2;
        check_pixel("cur_a", 200, 2, 1'b1, ref_rgb(200, 2, 1'b1, 2));
        for (int k = 0; k < 30; k++) frame_start();
        check_pixel("cur_b", 200, 2, 1'b1, ref_rgb(200, 2, 1'b1, 2));
        for (int k = 0; k < 30; k++) frame_start();
        check_pixel("cur_c", 200, 2, 1'b1, ref_rgb(200, 2, 1'b1, 2));
        check_pixel("cur_inner", 240, 40, 1'b1, ref_rgb(240, 40, 1'b1, 2));
        cursor_col = 3'd7;
        check_pixel("cur_none", 200, 2, 1'b1, 24'h0000C0);

        // Out-of-range writes are acknowledged and change nothing.
        do_write(4, 2, 3);
        frame_start();
        do_write(7, 2, 1);
        do_write(3, 6, 2);
        frame_start();
        check_pixel("oor_c42", 400, 200, 1'b1, 24'h00FF00);
        for (int i = 0; i < 7; i++)
            check_pixel($sformatf("oor_row2_%0d", i), 80 + 80 * i, 200, 1'b1,
                        ref_rgb(80 + 80 * i, 200, 1'b1, 7));

        // Random traffic against the model.
        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 3));
            if (op <= 1) begin
                do_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 6)),
                         int'($urandom_range(0, 3)));
            end else if (op == 2) begin
                frame_start();
            end
            cursor_col = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                x = int'($urandom_range(0, 639));
                y = int'($urandom_range(0, 479));
            end else begin
                c = int'($urandom_range(0, 6));
                r = int'($urandom_range(0, 5));
                x = 40 + 80 * c + int'($urandom_range(0, 79));
                y = 80 * r + int'($urandom_range(0, 79));
            end
            e = ref_rgb(x, y, ($urandom_range(0, 7) != 0), int'(cursor_col));
            check_pixel($sformatf("rand%0d(%0d,%0d)", it, x, y), x, y,
                        (e != 24'h0) || (x < 40 || x >= 600) ? 1'b1 : 1'b0, e);
        end

        // Reset in the middle of a clear.
        cursor_col = 3'd7;
        do_write(1, 1, 1);
        frame_start();
        check_pixel("mid_pre", 160, 120, 1'b1, 24'hFF0000);
        wr_if.clear = 1'b1;
        tick();
        wr_if.clear = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_rgb", {8'h00, red, green, blue}, 32'h0);
        check("mid_rst_ready", wr_if.wr_ready, 1);
        tick();
        reset = 1'b0;
        ref_reset();
        tick();
        check("mid_post_ready", wr_if.wr_ready, 1);
        frame_start();
        check_pixel("mid_post_cell", 160, 120, 1'b1, 24'h000000);
        check_pixel("mid_post_board", 45, 5, 1'b1, 24'h0000C0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
